// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map and bit positions for avalon_multi_timer
package timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int CTRL_ITO     = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_START   = 2;
  localparam int CTRL_STOP    = 3;
  localparam int CTRL_PRE_LSB = 8;
  localparam int CTRL_PRE_MSB = 15;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one interval-timer channel; prescaler built when TIMER_PRESCALER_EN is defined
module timer_channel
  import timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wr_en,
  input  logic [1:0]  i_reg_sel,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_snap;
  logic             r_ito;
  logic             r_cont;
  logic             r_run;
  logic             r_to;
  logic             r_force_reload;
  logic             r_zero_prev;

  logic             w_zero;
  logic             w_tick;
  logic             w_timeout;
  logic             w_wr_ctrl;
  logic [7:0]       w_pre_rd;

  assign w_zero    = (r_cnt == '0);
  assign w_timeout = w_zero & ~r_zero_prev;
  assign w_wr_ctrl = i_wr_en && (i_reg_sel == REG_CONTROL);
  assign o_irq     = r_to & r_ito;

`ifdef TIMER_PRESCALER_EN
  logic [7:0] r_pre;
  logic [7:0] r_pcnt;

  assign w_tick   = (r_pcnt == r_pre);
  assign w_pre_rd = r_pre;

  // Prescale counter advances only while running and restarts on every reload request
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_pre  <= 8'd0;
      r_pcnt <= 8'd0;
    end else begin
      if (r_run) r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
      if (r_force_reload) r_pcnt <= 8'd0;
      if (w_wr_ctrl) r_pre <= i_wdata[CTRL_PRE_MSB:CTRL_PRE_LSB];
    end
  end
`else
  assign w_tick   = 1'b1;
  assign w_pre_rd = 8'd0;
`endif

  // Counter, run state and register writes; later assignments carry the higher priority
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt          <= RST_CNT;
      r_period       <= RST_CNT;
      r_snap         <= '0;
      r_ito          <= 1'b0;
      r_cont         <= 1'b0;
      r_run          <= 1'b0;
      r_force_reload <= 1'b0;
      r_zero_prev    <= (RST_CNT == '0);
    end else begin
      r_zero_prev    <= w_zero;
      r_force_reload <= 1'b0;
      if (w_tick && r_run) begin
        if (w_zero) begin
          r_cnt <= r_period;
          if (!r_cont) r_run <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (r_force_reload) begin
        r_cnt <= r_period;
        r_run <= 1'b0;
      end
      if (i_wr_en) begin
        case (i_reg_sel)
          REG_CONTROL: begin
            r_ito  <= i_wdata[CTRL_ITO];
            r_cont <= i_wdata[CTRL_CONT];
            if (i_wdata[CTRL_START])     r_run <= 1'b1;
            else if (i_wdata[CTRL_STOP]) r_run <= 1'b0;
          end
          REG_PERIOD: begin
            r_period       <= i_wdata[CNT_W-1:0];
            r_force_reload <= 1'b1;
          end
          REG_SNAP: r_snap <= r_cnt;
          default: ;
        endcase
      end
    end
  end

  // Sticky timeout flag; a STATUS write in the same cycle as an event leaves it clear
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_to <= 1'b0;
    end else if (i_wr_en && (i_reg_sel == REG_STATUS)) begin
      r_to <= 1'b0;
    end else if (w_timeout) begin
      r_to <= 1'b1;
    end
  end

  // Read-back of the selected register for the top-level mux
  always_comb begin
    o_rdata = 32'd0;
    case (i_reg_sel)
      REG_STATUS: begin
        o_rdata[STAT_TO]  = r_to;
        o_rdata[STAT_RUN] = r_run;
      end
      REG_CONTROL: begin
        o_rdata[CTRL_ITO]                  = r_ito;
        o_rdata[CTRL_CONT]                 = r_cont;
        o_rdata[CTRL_PRE_MSB:CTRL_PRE_LSB] = w_pre_rd;
      end
      REG_PERIOD: o_rdata = 32'(r_period);
      REG_SNAP:   o_rdata = 32'(r_snap);
      default:    o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// rtl/avalon_multi_timer.sv - Avalon-MM multi-channel timer top; optional prescaler via TIMER_PRESCALER_EN
module avalon_multi_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  parameter int          ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [ADDR_W-1:0] w_ch_idx;
  logic [1:0]        w_reg_sel;
  logic              w_wr;
  logic [31:0]       w_ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] w_irq;
  logic [31:0]       w_rd_mux;
  logic [31:0]       r_readdata;

  assign w_ch_idx  = address >> 2;
  assign w_reg_sel = address[1:0];
  assign w_wr      = chipselect & ~write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .i_clk     (clk),
      .i_rstn    (reset_n),
      .i_wr_en   (w_wr && (w_ch_idx == ADDR_W'(i))),
      .i_reg_sel (w_reg_sel),
      .i_wdata   (writedata),
      .o_rdata   (w_ch_rdata[i]),
      .o_irq     (w_irq[i])
    );
  end

  // Select the addressed channel; undecoded channel indices read as zero
  always_comb begin
    w_rd_mux = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch_idx == ADDR_W'(i)) w_rd_mux = w_ch_rdata[i];
    end
  end

  // Read data register, refreshed every cycle independent of chipselect
  always_ff @(posedge clk) begin
    if (!reset_n) r_readdata <= 32'd0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq      = w_irq;
  assign irq_any  = |w_irq;

endmodule

// File: doc/avalon_multi_timer.md
# avalon_multi_timer

Parametrised multi-channel interval timer on an Avalon-MM slave, the next generation of the single-channel system timer in the Nios subsystem. It provides NUM_CH independent down-counters of CNT_W bits. Each channel has one-shot/continuous mode, snapshot capture and a sticky timeout flag, and drives a per-channel interrupt line. An optional per-channel prescaler is compiled in by macro.

## Interface
- NUM_CH, 4: channel count, 1..8.
- CNT_W, 32: counter/period width, 16..32.
- RESET_PERIOD, 49999: reset value of every PERIOD register and counter; truncated to CNT_W.
- ADDR_W, $clog2(NUM_CH)+2: derived; do not override.

- clk  in  1  single clock.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  ADDR_W  {channel, reg}: upper bits select channel, low 2 bits select register.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  NUM_CH  per-channel interrupt, level.
- irq_any  out  1  OR of irq.

## Operation
- Registers per channel: 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAP.
- STATUS read: bit0 TO (timeout occurred), bit1 RUN. Any write clears TO.
- CONTROL: bit0 ITO (irq enable), bit1 CONT (continuous), bit2 START, bit3 STOP.
  - START and STOP are action bits: they are not stored and read 0.
  - Bits [15:8] are PRE when the prescaler is compiled in.
- PERIOD: CNT_W-bit load value; upper bits read 0.
- A PERIOD write asserts force_reload for the next cycle. force_reload loads the counter from PERIOD, clears RUN, and resets the prescaler.
- SNAP write (any data): copies the live counter into the snapshot register. SNAP read returns the snapshot.
- Channel with no address decode (channel index ≥ NUM_CH): writes ignored, reads return 0.
- Counting: on each tick with RUN=1:
  - counter==0 → reload PERIOD;
  - otherwise → decrement.
- Counter==0 with CONT=0 clears RUN next cycle. The counter then holds the PERIOD value.
- Timeout event is the rising edge of counter==0, found by comparing with the previous cycle's value. It sets TO.
- irq[i] = TO[i] & ITO[i].
- PERIOD=0 in continuous mode: counter stays 0 and a timeout event fires once only (edge).

## Timing
- Read latency 1: readdata holds the data addressed at edge t from edge t+1. readdata updates every cycle regardless of chipselect.
- Register writes take effect at the edge where write is sampled. START sets RUN at that edge, so the first decrement happens on the following tick.
- Reset values:
  - readdata 0, irq 0, irq_any 0;
  - counters and PERIOD = RESET_PERIOD;
  - RUN 0, TO 0, CONTROL 0, snapshot 0, prescaler 0.
- Simultaneous events, required behaviour:
  - START and STOP in the same write: START wins.
  - STATUS write and timeout event in the same cycle: the clear wins.
  - START while force_reload is pending: START wins; the counter reloads that cycle.
  - SNAP in the same cycle as a decrement: the pre-decrement value is captured.
- reset_n low mid-count returns the channel to reset values at the next edge. No partial state survives.
- irq is combinational from registered TO/ITO, so it adds no latency beyond the TO register.

## Configuration
- TIMER_PRESCALER_EN defined:
  - each channel has an 8-bit prescale counter;
  - tick = (prescale counter == PRE); the prescale counter wraps to 0 on tick;
  - PRE=0 gives a tick every cycle;
  - the prescaler runs only while RUN=1.
- Undefined: tick = 1 every cycle, CONTROL[15:8] is not stored and reads 0, and no prescale logic is generated.

## Structure
- Package timer_pkg holds:
  - register offsets REG_STATUS/REG_CONTROL/REG_PERIOD/REG_SNAP;
  - CONTROL bit indices (ITO, CONT, START, STOP, PRE_LSB/PRE_MSB);
  - STATUS bit indices.
- Sub-module timer_channel holds one counter, PERIOD, CONTROL, TO/RUN, snapshot and the optional prescaler. It is instantiated NUM_CH times via generate.
- The top level holds only the address decode, the registered read mux and the irq_any reduction.

## Test plan
- Reset, then read ch0 PERIOD → 49999. Read STATUS → 0. irq=0.
- ch1: PERIOD=9, CONTROL=0x7 (ITO|CONT|START) → TO rises 10 ticks after the count reaches 0. irq[1]=1 and irq_any=1. A STATUS write clears both, and TO sets again 10 cycles later.
- ch2 one-shot: PERIOD=4, CONTROL=0x5 (ITO|START) → one timeout, then RUN=0 and the counter holds 4. A SNAP write then read → 4.
- ch0 running, PERIOD rewritten to 100 mid-count → RUN=0 the next cycle and the counter is 100. CONTROL write of 0xC (START|STOP) → RUN=1.
- STATUS write on the exact timeout cycle → TO stays 0 and irq stays low.
- TIMER_PRESCALER_EN: PRE=3, PERIOD=2, CONT → timeouts every 12 cycles. Without the macro, CONTROL[15:8] reads 0 and the period is 3 cycles.
